times_table_engine: RTL and testbench
=====================================

Name: times_table_engine

Overview:
- Parametrised successor to the fixed 3x3-bit times-table memory.
- Builds its own AxB product table in on-chip RAM after reset, using a sequential init state machine (no preloaded coefficient file).
- Serves lookups through a valid/ready request channel and a registered, back-pressurable result channel.
- Sits between operand producers and any arithmetic consumer that needs single-cycle-latency products from a memory.

Parameters:
- A_W, 3, operand a width in bits.
- B_W, 3, operand b width in bits.
- RES_W, A_W+B_W, result width; must be at least A_W+B_W.
- CNT_W, 16, width of the served-lookup counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  engine can accept a request this cycle.
- a  in  A_W  multiplicand.
- b  in  B_W  multiplier.
- out_valid  out  1  result register holds an unconsumed product.
- out_ready  in  1  consumer accepts the result.
- result  out  RES_W  a*b, unsigned.
- rebuild  in  1  request a table rebuild (pulse).
- busy  out  1  table init in progress.
- lookup_cnt  out  CNT_W  number of results consumed, wrapping.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values: state=INIT, init address=0, accumulator=0, out_valid=0, result=0, lookup_cnt=0, busy=1, in_ready=0. Table RAM contents are not reset.
- Table: DEPTH = 2^(A_W+B_W) words of RES_W bits. Address = {a,b}, with a in the MSBs.
- State INIT:
  - Address counter sweeps 0..DEPTH-1, one write per cycle; b is the fast index.
  - When b==0: acc=0, write 0. Otherwise acc=acc+a (zero-extended to RES_W), write acc.
  - No multiplier in the datapath: adder only.
  - After the write at DEPTH-1 (cycle DEPTH-1 after reset release), go to RUN. busy drops to 0 on the same edge.
  - busy=1 and in_ready=0 throughout INIT.
- State RUN:
  - in_ready = !rebuild && (!out_valid || out_ready).
  - Handshake fires when in_valid && in_ready. The RAM is read synchronously: result and out_valid=1 appear on the next edge (latency 1).
  - If out_valid && !out_ready, result and out_valid hold stable and no new request is accepted.
  - Back-to-back throughput is one result per cycle while out_ready=1.
  - If out_ready=1 with no new request, out_valid clears next edge; result keeps its last value.
- lookup_cnt increments on each out_valid && out_ready and wraps to 0 after 2^CNT_W-1.
- Rebuild:
  - Sampled only in RUN. It forces in_ready=0 that cycle, so a simultaneous in_valid is not accepted (rebuild wins).
  - If out_valid=1, rebuild is taken only once the pending result is consumed (out_valid && out_ready, or out_valid=0). Until then the engine stays in RUN with in_ready=0, provided rebuild stays high. rebuild must be held until busy rises.
  - On entry to INIT the address and accumulator clear. lookup_cnt is preserved.
- Reset mid-INIT or mid-RUN: immediate return to the reset values; the sweep restarts from address 0 after release.
- Arithmetic: all unsigned. The maximum product (2^A_W-1)(2^B_W-1) fits in A_W+B_W bits, so there is no overflow.
- Inputs a and b are ignored unless the handshake fires.
- Requests during INIT are held off by the producer, which keeps in_valid high until in_ready.

Decomposition:
- Package times_table_pkg:
  - state enum {INIT, RUN};
  - default width constants;
  - function depth(aw,bw).
- Sub-module tt_ram:
  - simple dual-port RAM, parametrised by width and depth;
  - write port used by INIT, registered read port used by RUN;
  - written so synthesis infers block RAM.
- Top level holds the FSM, accumulator, handshake and counter.

Test Plan:
- Reset release, defaults: busy=1 and in_ready=0 for exactly 64 cycles, then busy=0 and in_ready=1. Issue in_valid with a=7, b=7: one cycle later out_valid=1, result=49.
- Exhaustive sweep: all 64 {a,b} pairs back-to-back with out_ready=1. Each result equals a*b, one per cycle. lookup_cnt ends at 64.
- Back-pressure: request a=5, b=6, hold out_ready=0 for 4 cycles. result stays 30, out_valid stays 1, in_ready=0, and a second in_valid (3x3) is not accepted. Raise out_ready: next result is 9 the cycle after acceptance.
- Rebuild collision: rebuild=1 and in_valid=1 (a=2, b=3) in the same cycle. Request not accepted, busy=1 for 64 cycles. Afterwards the retried request returns 6.
- Reset mid-init: assert rst_n=0 at init cycle 20, release. busy is high for a full 64 cycles and a=7, b=1 returns 7.
- Counter wrap (CNT_W=4): 17 consumed lookups leave lookup_cnt=1. A parametrised build with A_W=4, B_W=4 returns 15*15=225 after 256 init cycles.

Source files
------------

// File: rtl/times_table_pkg.sv
// Shared types and constants for the times-table engine: FSM state encoding,
// default operand widths and the table depth helper.
package times_table_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_A_W   = 3;
    localparam int DEF_B_W   = 3;
    localparam int DEF_CNT_W = 16;

    function automatic int depth(input int aw, input int bw);
        return 1 << (aw + bw);
    endfunction

endpackage

// File: rtl/tt_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// No reset on storage or read register so it maps onto block RAM.
module tt_ram #(
    parameter int WIDTH  = 6,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/times_table_engine.sv
// Times-table lookup engine: fills its own product table with an adder-only
// sweep after reset/rebuild, then serves {a,b} lookups with one-cycle latency.
module times_table_engine
    import times_table_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int RES_W = A_W + B_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    input  logic             rebuild,
    output logic             busy,
    output logic [CNT_W-1:0] lookup_cnt
);

    localparam int ADDR_W = A_W + B_W;
    localparam int DEPTH  = depth(A_W, B_W);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [RES_W-1:0]  r_acc;
    logic [RES_W-1:0]  w_acc_next;
    logic              r_out_valid;
    logic              r_have_data;
    logic [CNT_W-1:0]  r_lookup_cnt;
    logic [A_W-1:0]    w_init_a;
    logic [B_W-1:0]    w_init_b;
    logic              w_init_we;
    logic              w_init_done;
    logic              w_slot_free;
    logic              w_fire;
    logic              w_consume;
    logic              w_rebuild_go;
    logic [RES_W-1:0]  w_ram_rdata;

    assign w_init_a     = r_addr[ADDR_W-1:B_W];
    assign w_init_b     = r_addr[B_W-1:0];
    assign w_init_we    = (r_state == INIT);
    assign w_init_done  = w_init_we && (&r_addr);
    // Each row restarts at zero and adds a once per step of b.
    assign w_acc_next   = (w_init_b == '0) ? '0 : r_acc + RES_W'(w_init_a);

    assign w_slot_free  = !r_out_valid || out_ready;
    assign in_ready     = (r_state == RUN) && !rebuild && w_slot_free;
    assign w_fire       = in_valid && in_ready;
    assign w_consume    = r_out_valid && out_ready;
    assign w_rebuild_go = (r_state == RUN) && rebuild && w_slot_free;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT:    if (w_init_done)  w_state_next = RUN;
            RUN:     if (w_rebuild_go) w_state_next = INIT;
            default: w_state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_acc  <= '0;
        end else if (r_state == INIT) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_acc  <= w_acc_next;
        end else if (w_rebuild_go) begin
            r_addr <= '0;
            r_acc  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_have_data  <= 1'b0;
            r_lookup_cnt <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_have_data <= 1'b1;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            if (w_consume) begin
                r_lookup_cnt <= r_lookup_cnt + CNT_W'(1);
            end
        end
    end

    tt_ram #(
        .WIDTH  (RES_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_init_we),
        .i_waddr (r_addr),
        .i_wdata (w_acc_next),
        .i_re    (w_fire),
        .i_raddr ({a, b}),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register has no reset; show zero until the first lookup lands.
    assign result     = r_have_data ? w_ram_rdata : '0;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state == INIT);
    assign lookup_cnt = r_lookup_cnt;

endmodule

// File: tb/tb_times_table_engine.sv
// Self-checking bench: default 3x3 engine plus a 4x4 build with a 4-bit counter,
// checked against plain a*b arithmetic and a handshake-level model.
module tb_times_table_engine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  result;
    logic        rebuild;
    logic        busy;
    logic [15:0] lookup_cnt;

    logic        rst1_n;
    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [3:0]  d1_a;
    logic [3:0]  d1_b;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [7:0]  d1_result;
    logic        d1_rebuild;
    logic        d1_busy;
    logic [3:0]  d1_lookup_cnt;

    int n_checks = 0;
    int n_errors = 0;

    times_table_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .rebuild    (rebuild),
        .busy       (busy),
        .lookup_cnt (lookup_cnt)
    );

    times_table_engine #(.A_W(4), .B_W(4), .CNT_W(4)) dut1 (
        .clk        (clk),
        .rst_n      (rst1_n),
        .in_valid   (d1_in_valid),
        .in_ready   (d1_in_ready),
        .a          (d1_a),
        .b          (d1_b),
        .out_valid  (d1_out_valid),
        .out_ready  (d1_out_ready),
        .result     (d1_result),
        .rebuild    (d1_rebuild),
        .busy       (d1_busy),
        .lookup_cnt (d1_lookup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until busy drops; in_ready must stay low meanwhile.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            check("init_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            n++;
        end
    endtask

    // Hold a request until the engine accepts it (bounded).
    task automatic send(input int av, input int bv, output bit ok);
        in_valid = 1'b1;
        a = 3'(av);
        b = 3'(bv);
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            #1;
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
    endtask

    int perm [64];
    int n;
    int tmp;
    int j;
    int p;
    int cnt_model;
    int av;
    int bv;
    bit ok;
    bit iv;
    bit ordy;
    bit m_ov;
    int m_res;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; rebuild = 1'b0;
        rst1_n = 1'b0; d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_out_ready = 1'b0; d1_rebuild = 1'b0;
        cnt_model = 0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {26'd0, result}, 32'd0);
        check("rst_lookup_cnt", {16'd0, lookup_cnt}, 32'd0);

        rst_n = 1'b1;
        count_busy(n);
        check("init_cycles", n, 64);
        out_ready = 1'b1;
        #1;
        check("run_in_ready", {31'd0, in_ready}, 32'd1);
        send(7, 7, ok);
        check("first_accept", {31'd0, ok}, 32'd1);
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_result", {26'd0, result}, 32'd49);
        step();
        cnt_model = 1;
        check("first_drain", {31'd0, out_valid}, 32'd0);
        check("first_cnt", {16'd0, lookup_cnt}, 32'(cnt_model));

        // Exhaustive sweep in shuffled order, back to back.
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 64; i++) begin
            p = perm[i];
            in_valid = 1'b1;
            a = 3'(p / 8);
            b = 3'(p % 8);
            step();
            check("sweep_valid", {31'd0, out_valid}, 32'd1);
            check("sweep_result", {26'd0, result}, 32'((p / 8) * (p % 8)));
        end
        in_valid = 1'b0;
        step();
        cnt_model += 64;
        check("sweep_drain", {31'd0, out_valid}, 32'd0);
        check("sweep_cnt", {16'd0, lookup_cnt}, 32'(cnt_model));

        // Back-pressure: 5x6 held, 3x3 must wait.
        out_ready = 1'b0;
        send(5, 6, ok);
        check("bp_result", {26'd0, result}, 32'd30);
        in_valid = 1'b1; a = 3'd3; b = 3'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_result", {26'd0, result}, 32'd30);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        cnt_model++;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_result", {26'd0, result}, 32'd9);
        in_valid = 1'b0;
        step();
        cnt_model++;
        check("bp_cnt", {16'd0, lookup_cnt}, 32'(cnt_model));

        // Rebuild collides with a request; rebuild wins, request retried after.
        rebuild = 1'b1;
        in_valid = 1'b1; a = 3'd2; b = 3'd3;
        #1;
        check("rb_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("rb_busy", {31'd0, busy}, 32'd1);
        rebuild = 1'b0;
        count_busy(n);
        check("rb_cycles", n, 64);
        check("rb_ready_after", {31'd0, in_ready}, 32'd1);
        step();
        check("rb_retry_valid", {31'd0, out_valid}, 32'd1);
        check("rb_retry_result", {26'd0, result}, 32'd6);
        in_valid = 1'b0;
        step();
        cnt_model++;
        check("rb_cnt_kept", {16'd0, lookup_cnt}, 32'(cnt_model));

        // Random traffic against a handshake-level model.
        m_ov = 1'b0;
        m_res = 0;
        for (int k = 0; k < 80; k++) begin
            iv = 1'($urandom_range(0, 1));
            av = int'($urandom_range(0, 7));
            bv = int'($urandom_range(0, 7));
            ordy = ($urandom_range(0, 3) != 0);
            in_valid = iv; a = 3'(av); b = 3'(bv); out_ready = ordy;
            #1;
            check("rand_in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || ordy)});
            if (m_ov && ordy) cnt_model++;
            if (iv && (!m_ov || ordy)) begin
                m_ov = 1'b1;
                m_res = av * bv;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            step();
            check("rand_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) check("rand_result", {26'd0, result}, 32'(m_res));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        if (m_ov) cnt_model++;
        check("rand_cnt", {16'd0, lookup_cnt}, 32'(cnt_model));

        // Reset in the middle of the init sweep.
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", {26'd0, result}, 32'd0);
        check("mid_rst_cnt", {16'd0, lookup_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("mid_init_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy(n);
        check("mid_rst_cycles", n, 64);
        send(7, 1, ok);
        check("mid_rst_accept", {31'd0, ok}, 32'd1);
        check("mid_rst_lookup", {26'd0, result}, 32'd7);
        step();
        check("mid_rst_cnt_after", {16'd0, lookup_cnt}, 32'd1);

        // 4x4 build with a 4-bit wrapping counter.
        rst1_n = 1'b1;
        n = 0;
        while (d1_busy === 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check("w4_init_cycles", n, 256);
        d1_out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            av = (k == 0) ? 15 : int'($urandom_range(0, 15));
            bv = (k == 0) ? 15 : int'($urandom_range(0, 15));
            d1_in_valid = 1'b1; d1_a = 4'(av); d1_b = 4'(bv);
            #1;
            check("w4_in_ready", {31'd0, d1_in_ready}, 32'd1);
            step();
            check("w4_valid", {31'd0, d1_out_valid}, 32'd1);
            check("w4_result", {24'd0, d1_result}, 32'(av * bv));
        end
        d1_in_valid = 1'b0;
        step();
        check("w4_drain", {31'd0, d1_out_valid}, 32'd0);
        check("w4_cnt_wrap", {28'd0, d1_lookup_cnt}, 32'(17 % 16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
